// File: rtl/tmip_pkg.sv
// tmip_pkg
//   Shared definitions for the TMIP result collector: word/index widths,
//   frame size encoding, FSM states and the buffered result record.
package tmip_pkg;

    localparam int unsigned WORD_W     = 20;  // bits per serial result word
    localparam int unsigned IDX_W      = 8;   // word index width (up to 256 words)
    localparam int unsigned FIFO_DEPTH = 4;   // result FIFO entries (power of two)

    typedef enum logic [1:0] {
        SZ_4    = 2'd0,
        SZ_8    = 2'd1,
        SZ_16   = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } result_t;

    // Number of words in a frame; one extra bit so 256 is representable.
    function automatic logic [IDX_W:0] size_words(input size_e sz);
        logic [IDX_W:0] n;
        n = '0;
        case (sz)
            SZ_4:    n = (IDX_W+1)'(16);
            SZ_8:    n = (IDX_W+1)'(64);
            SZ_16:   n = (IDX_W+1)'(256);
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tmip_result_fifo.sv
// tmip_result_fifo
//   Synchronous FIFO of result_t records. The head entry is read directly
//   from the storage registers, so a pushed word is visible the cycle after
//   the push. A push into a full FIFO is accepted only when a pop happens in
//   the same cycle.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (clears storage)
//     push, din  write request and record
//     pop        read request (ignored when empty)
//     dout       head record
//     full       DEPTH entries held
//     empty      no entries held
module tmip_result_fifo
    import tmip_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  result_t din,
    input  logic    pop,
    output result_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (PTR_W+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tmip_out_collector.sv
// tmip_out_collector
//   Deserializes the TMIP engine's MSB-first serial result stream into
//   WORD_W-bit words, buffers them with raster index and last-of-frame flag
//   in a small FIFO, tracks the frame maximum and flags protocol errors.
//   Word/index widths come from tmip_pkg.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     cfg_valid, cfg_size  frame start strobe and size (0:16, 1:64, 2:256 words)
//     ser_valid, ser_bit   serial result stream
//     word_valid/ready     FIFO head handshake
//     word_data/idx/last   FIFO head value, index, final-word flag
//     frame_done           one-cycle pulse after the last word is assembled
//     max_val, max_idx     largest word of the frame and its index
//     err_overflow         sticky: word dropped, FIFO full
//     err_gap              sticky: ser_valid dropped mid-word
//     err_unexp            sticky: data while idle, or reserved size
module tmip_out_collector
    import tmip_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = tmip_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_size,
    input  logic              ser_valid,
    input  logic              ser_bit,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_last,
    output logic              frame_done,
    output logic [WORD_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx,
    output logic              err_overflow,
    output logic              err_gap,
    output logic              err_unexp
);

    localparam int unsigned BIT_W = $clog2(WORD_W);

    state_e            state_q;
    logic [IDX_W:0]    total_q;
    logic [IDX_W:0]    word_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shift_reg;

    logic              word_done;
    logic [WORD_W-1:0] new_word;
    logic              is_last;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    result_t           push_rec;
    result_t           head;

    always_comb begin
        word_done = (state_q == ST_COLLECT) && ser_valid
                    && (bit_cnt == BIT_W'(WORD_W-1));
        new_word  = {shift_reg[WORD_W-2:0], ser_bit};
        is_last   = (word_cnt == total_q - 1'b1);
        pop       = !fifo_empty && word_ready;
        push_rec  = '{data: new_word, idx: word_cnt[IDX_W-1:0], last: is_last};
    end

    tmip_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_done),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        word_valid = !fifo_empty;
        word_data  = head.data;
        word_idx   = head.idx;
        word_last  = head.last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            total_q      <= '0;
            word_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            frame_done   <= 1'b0;
            max_val      <= '0;
            max_idx      <= '0;
            err_overflow <= 1'b0;
            err_gap      <= 1'b0;
            err_unexp    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A same-cycle pop frees the slot, so only full-without-pop drops.
            if (word_done && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ser_valid) begin
                        err_unexp <= 1'b1;
                    end
                    if (cfg_valid) begin
                        if (size_e'(cfg_size) == SZ_RSVD) begin
                            err_unexp <= 1'b1;
                        end else begin
                            total_q  <= size_words(size_e'(cfg_size));
                            word_cnt <= '0;
                            bit_cnt  <= '0;
                            max_val  <= '0;
                            max_idx  <= '0;
                            state_q  <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (ser_valid) begin
                        shift_reg <= new_word;
                        if (word_done) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                            // First word always seeds the max; ties keep the earlier index.
                            if (word_cnt == '0 || new_word > max_val) begin
                                max_val <= new_word;
                                max_idx <= word_cnt[IDX_W-1:0];
                            end
                            if (is_last) begin
                                frame_done <= 1'b1;
                                state_q    <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (bit_cnt != '0) begin
                        bit_cnt <= '0;
                        err_gap <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmip_out_collector.sv
// tb_tmip_out_collector
//   Directed scenarios plus randomized frames, checked every cycle against a
//   word-level reference model (queue for the FIFO, integers for counters).
module tb_tmip_out_collector;

    localparam int unsigned W = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [1:0]  cfg_size;
    logic        ser_valid;
    logic        ser_bit;
    logic        word_valid;
    logic        word_ready;
    logic [19:0] word_data;
    logic [7:0]  word_idx;
    logic        word_last;
    logic        frame_done;
    logic [19:0] max_val;
    logic [7:0]  max_idx;
    logic        err_overflow;
    logic        err_gap;
    logic        err_unexp;

    tmip_out_collector #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_size     (cfg_size),
        .ser_valid    (ser_valid),
        .ser_bit      (ser_bit),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_idx     (word_idx),
        .word_last    (word_last),
        .frame_done   (frame_done),
        .max_val      (max_val),
        .max_idx      (max_idx),
        .err_overflow (err_overflow),
        .err_gap      (err_gap),
        .err_unexp    (err_unexp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 1;  // 0: never ready, 1: always ready, 2: random

    // Reference model state
    typedef struct {
        int unsigned d;
        int unsigned i;
        bit          l;
    } exp_t;
    exp_t        q[$];
    bit          m_collect;
    int unsigned m_total, m_wcnt, m_bits, m_acc, m_maxv, m_maxi;
    bit          m_fd, m_ovf, m_gap, m_unexp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_collect = 0; m_total = 0; m_wcnt = 0; m_bits = 0; m_acc = 0;
        m_maxv = 0; m_maxi = 0; m_fd = 0; m_ovf = 0; m_gap = 0; m_unexp = 0;
    endtask

    // Apply the spec rules for one clock edge using the current inputs.
    task automatic model_step();
        bit          pop;
        bit          fd_n;
        exp_t        e;
        pop  = word_ready && (q.size() > 0);
        fd_n = 0;
        if (pop) void'(q.pop_front());
        if (!m_collect) begin
            if (ser_valid) m_unexp = 1;
            if (cfg_valid) begin
                if (cfg_size == 2'd3) m_unexp = 1;
                else begin
                    m_total = 16 << (2 * cfg_size);
                    m_wcnt = 0; m_bits = 0; m_maxv = 0; m_maxi = 0;
                    m_collect = 1;
                end
            end
        end else if (ser_valid) begin
            if (m_bits == 0) m_acc = 0;
            m_acc = (m_acc * 2 + ser_bit) % (1 << W);
            m_bits++;
            if (m_bits == W) begin
                e.d = m_acc; e.i = m_wcnt; e.l = (m_wcnt == m_total - 1);
                if (q.size() < 4) q.push_back(e);
                else m_ovf = 1;
                if (m_wcnt == 0 || m_acc > m_maxv) begin
                    m_maxv = m_acc; m_maxi = m_wcnt;
                end
                m_wcnt++;
                m_bits = 0;
                if (e.l) begin
                    m_collect = 0;
                    fd_n = 1;
                end
            end
        end else if (m_bits != 0) begin
            m_bits = 0;
            m_gap = 1;
        end
        m_fd = fd_n;
    endtask

    // One cycle: pick ready, compare at negedge, advance model, edge, settle.
    task automatic tick();
        case (rdy_mode)
            0:       word_ready = 1'b0;
            1:       word_ready = 1'b1;
            default: word_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        check("word_valid", word_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("word_data", word_data, q[0].d);
            check("word_idx", word_idx, q[0].i);
            check("word_last", word_last, q[0].l);
        end
        check("frame_done", frame_done, m_fd);
        check("max_val", max_val, m_maxv);
        check("max_idx", max_idx, m_maxi);
        check("err_overflow", err_overflow, m_ovf);
        check("err_gap", err_gap, m_gap);
        check("err_unexp", err_unexp, m_unexp);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [19:0] val, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            ser_valid = 1'b1;
            ser_bit   = val[b];
            tick();
        end
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
    endtask

    task automatic send_word(input logic [19:0] val);
        send_range(val, 19, 0);
    endtask

    task automatic idle(input int n);
        ser_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cfg(input logic [1:0] sz);
        cfg_valid = 1'b1;
        cfg_size  = sz;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input bit check_zero);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        if (check_zero) begin
            check("rst_word_valid", word_valid, 0);
            check("rst_word_data", word_data, 0);
            check("rst_word_idx", word_idx, 0);
            check("rst_word_last", word_last, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_max_val", max_val, 0);
            check("rst_max_idx", max_idx, 0);
            check("rst_err_overflow", err_overflow, 0);
            check("rst_err_gap", err_gap, 0);
            check("rst_err_unexp", err_unexp, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v;
        int unsigned r;
        rst = 1'b1; cfg_valid = 1'b0; cfg_size = 2'd0;
        ser_valid = 1'b0; ser_bit = 1'b0; word_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Frame 1: ascending words, always ready
        rdy_mode = 1;
        cfg(2'd0);
        for (int i = 1; i <= 16; i++) send_word(20'(i));
        idle(3);
        check("f1_max_val", max_val, 20'h00010);
        check("f1_max_idx", max_idx, 15);
        check("f1_errs", {err_overflow, err_gap, err_unexp}, 0);

        // Frame 2: ties on the maximum, earliest index wins
        cfg(2'd0);
        send_word(20'h00005);
        send_word(20'hFFFFF);
        send_word(20'hFFFFF);
        send_word(20'h00003);
        for (int i = 4; i < 16; i++) send_word(20'($urandom_range(0, 20'hFFFFE)));
        idle(3);
        check("f2_max_val", max_val, 20'hFFFFF);
        check("f2_max_idx", max_idx, 1);

        // Frame 3: consumer stalled, only first 4 words survive
        rdy_mode = 0;
        cfg(2'd1);
        for (int i = 0; i < 64; i++) send_word(20'($urandom));
        idle(2);
        check("f3_overflow", err_overflow, 1);
        rdy_mode = 1;
        idle(8);
        check("f3_drained", word_valid, 0);

        // Frame 4: full FIFO popped on the cycle the 5th word completes
        do_reset(1'b0);
        rdy_mode = 0;
        cfg(2'd0);
        for (int i = 0; i < 4; i++) send_word(20'($urandom));
        v = 20'($urandom);
        send_range(v, 19, 1);
        rdy_mode = 1;
        send_range(v, 0, 0);
        check("f4_no_overflow", err_overflow, 0);
        for (int i = 5; i < 16; i++) send_word(20'($urandom));
        idle(6);
        check("f4_no_overflow_end", err_overflow, 0);

        // Frame 5: ser_valid drops after 7 bits of word 2
        rdy_mode = 0;
        cfg(2'd0);
        send_word(20'($urandom));
        send_word(20'($urandom));
        idle(4);  // let nothing pop so word 2 lands at a known position
        rdy_mode = 1;
        idle(3);
        rdy_mode = 0;
        send_range(20'($urandom), 19, 13);
        idle(1);
        check("f5_gap", err_gap, 1);
        send_word(20'hABCDE);
        check("f5_head_data", word_data, 20'hABCDE);
        check("f5_head_idx", word_idx, 2);
        rdy_mode = 2;
        while (m_collect) send_word(20'($urandom));
        idle(6);

        // Reset mid-frame, then unexpected data in IDLE and reserved size
        do_reset(1'b0);
        rdy_mode = 2;
        cfg(2'd1);
        for (int i = 0; i < 30; i++) send_word(20'($urandom));
        do_reset(1'b1);
        rdy_mode = 1;
        send_range(20'($urandom), 19, 17);
        idle(1);
        check("idle_unexp", err_unexp, 1);
        check("idle_no_word", word_valid, 0);
        do_reset(1'b0);
        cfg(2'd3);
        check("rsvd_unexp", err_unexp, 1);
        send_word(20'($urandom));
        idle(2);
        check("rsvd_no_word", word_valid, 0);

        // Randomized frames
        do_reset(1'b0);
        rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            cfg((f == 3) ? 2'd2 : 2'($urandom_range(0, 1)));
            while (m_collect) begin
                r = $urandom_range(0, 31);
                v = ($urandom_range(0, 3) == 0) ? 20'h00007 : 20'($urandom);
                if (r == 0) begin
                    send_range(v, 19, int'($urandom_range(1, 19)));
                    idle(1);
                end else if (r == 1) begin
                    cfg_valid = 1'b1;
                    cfg_size  = 2'($urandom);
                    idle(1);
                    cfg_valid = 1'b0;
                end else begin
                    send_word(v);
                    if (r < 5) idle(int'($urandom_range(1, 2)));
                end
            end
            idle(int'($urandom_range(0, 3)));
        end
        rdy_mode = 1;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
